// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side signal bundle for the simulink-to-PPC read-back register.
// The master modport is the bus side; the slave modport is the register.
interface opb_register_simulink2ppc_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [0:AW-1]     OPB_ABus;
    logic [0:DW/8-1]   OPB_BE;
    logic [0:DW-1]     OPB_DBus;
    logic              OPB_RNW;
    logic              OPB_select;
    logic              OPB_seqAddr;
    logic [0:DW-1]     Sl_DBus;
    logic              Sl_xferAck;
    logic              Sl_errAck;
    logic              Sl_retry;
    logic              Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// OPB read-back register: captures a fabric word on user_valid and serves it,
// plus a status word (update count, sticky new flag, freeze bit), to the PPC.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for an address hit; snapshot/side effects on hit
//   ST_ACK  | Sl_xferAck high, Sl_DBus carries the read snapshot
//   ST_TURN | bus turnaround; select ignored, outputs low
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    opb_register_simulink2ppc_if.slave   opb,
    input  logic [31:0]                  user_data_in,
    input  logic                         user_valid,
    output logic                         user_frozen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [5:0]              reg_sel;
    logic                    in_range;
    logic                    hit;
    logic                    sel_data;
    logic                    sel_status;
    logic                    capture;
    logic                    wr_status;
    logic                    new_clr;

    logic [31:0]             cap;
    logic [15:0]             update_count;
    logic                    new_flag;
    logic                    freeze;
    logic [C_OPB_DWIDTH-1:0] rd_word;
    logic [C_OPB_DWIDTH-1:0] rd_q;

    assign addr       = opb.OPB_ABus;
    assign reg_sel    = opb.OPB_ABus[24:29];
    assign in_range   = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign hit        = opb.OPB_select && in_range && (state == ST_IDLE);
    assign sel_data   = (reg_sel == 6'd0);
    assign sel_status = (reg_sel == 6'd1);

    // freeze gates the strobe completely, so a frozen word never moves
    assign capture    = user_valid && !freeze;
    assign wr_status  = hit && !opb.OPB_RNW && sel_status && opb.OPB_BE[3];
    assign new_clr    = (hit && opb.OPB_RNW && sel_data) ||
                        (wr_status && opb.OPB_DBus[30]);

    always_comb begin
        rd_word = '0;
        if (sel_data)
            rd_word = cap;
        else if (sel_status)
            rd_word = {update_count, 14'd0, new_flag, freeze};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hit) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_TURN;
            ST_TURN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            cap          <= '0;
            update_count <= '0;
            new_flag     <= 1'b0;
            freeze       <= 1'b0;
            rd_q         <= '0;
        end else begin
            if (capture) begin
                cap          <= user_data_in;
                update_count <= update_count + 16'd1;
            end
            // a capture in the same cycle as a clear leaves the flag set
            if (capture)
                new_flag <= 1'b1;
            else if (new_clr)
                new_flag <= 1'b0;
            if (wr_status)
                freeze <= opb.OPB_DBus[31];
            rd_q <= (hit && opb.OPB_RNW) ? rd_word : '0;
        end
    end

    assign opb.Sl_DBus    = rd_q;
    assign opb.Sl_xferAck = (state == ST_ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign user_frozen    = freeze;

    logic unused_ok;
    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:29],
                         |C_FAMILY};

endmodule

// File: doc/opb_register_simulink2ppc.md
# opb_register_simulink2ppc

OPB slave register that carries a 32-bit value from fabric (Simulink) logic to the PowerPC, the read-back counterpart of the PPC-to-Simulink software register. Fabric logic presents a word with a valid strobe; the block captures it and serves it on OPB reads, along with a status word. The status word holds a sticky new-data flag, a wrapping update counter and a software-controlled freeze bit. It sits on the design's OPB bus alongside the other software registers, in the OPB_Clk domain.

## Interface
- C_BASEADDR, 32'hFFFFFFFF: first byte address of the 256-byte window.
- C_HIGHADDR, 32'h00000000: last byte address of the window.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width.
- C_FAMILY, "virtex5": target family; informational only.

One clock; reset is asynchronous and active-high.
- OPB_Clk  in  1  sole clock; all state is on its rising edge.
- OPB_Rst  in  1  asynchronous, active-high reset.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables. OPB_BE[3] covers OPB_DBus[24:31].
- OPB_DBus  in  [0:31]  write data, big-endian: bit 0 is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data. Non-zero only in the acknowledge cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  constant 0.
- user_data_in  in  [31:0]  fabric word.
- user_valid  in  1  capture strobe for user_data_in.
- user_frozen  out  1  current freeze bit, exported to fabric.

## Operation
- Register map, byte offset from C_BASEADDR. Word bit 31 maps to Sl_DBus[0].
  - 0x0 DATA (RO): the captured word.
  - 0x4 STATUS: [31:16] update_count (RO); [1] new_flag (RO, write-1-to-clear); [0] freeze (RW).
  - 0x8–0xFF: reads return 0; writes are acknowledged and discarded.
- Capture: when user_valid=1 and freeze=0, the block loads cap <= user_data_in, sets new_flag <= 1 and increments update_count modulo 2^16 (0xFFFF wraps to 0x0000).
  - When freeze=1, user_valid is ignored entirely: cap, new_flag and update_count all hold.
- Address hit: OPB_select=1, C_BASEADDR <= OPB_ABus <= C_HIGHADDR, and the state is IDLE.
  - The decode uses OPB_ABus[24:29]. The low two bits are ignored.
- Bus FSM (IDLE, ACK, TURN):
  - IDLE to ACK on an address hit. In the hit cycle the read word is snapshotted into the output register and any write side effect is applied.
  - ACK: Sl_xferAck=1 and Sl_DBus carries the snapshot on a read, 0 on a write. Always goes to TURN.
  - TURN: outputs are 0 and OPB_select is ignored. Always goes to IDLE.
- A read of DATA clears new_flag in the hit cycle.
- Writes to STATUS:
  - When OPB_BE[3]=1: freeze <= OPB_DBus[31], and OPB_DBus[30]=1 clears new_flag.
  - When OPB_BE[3]=0: the write is acknowledged with no effect.
- Simultaneous events in the same cycle:
  - A capture and a DATA read (or a write-1-clear of new_flag): the set wins, so new_flag=1. The read returns the old cap, and the new cap is visible on the next read.
  - A capture and a freeze-setting write: the capture completes this cycle, and freeze takes effect from the next cycle.
- Reset: cap=0, new_flag=0, update_count=0, freeze=0, state=IDLE. All outputs are 0 (Sl_DBus, Sl_xferAck, user_frozen).
  - Reset mid-transfer aborts it; no ack is issued after reset.

## Timing
- Read/write latency: select and hit sampled at edge N; Sl_xferAck is high during cycle N+1, for exactly 1 cycle.
- Back-to-back transfers: the minimum spacing from one ack to the next ack is 3 cycles (ACK, TURN, IDLE-hit, then ACK).
- Capture latency: user_valid at edge N makes cap, new_flag and update_count visible to a read whose hit is at edge N+1 or later.
- user_frozen changes 1 cycle after the write hit edge, registered.
- Read coherency: Sl_DBus is registered and stable throughout the ack cycle, independent of user_valid activity during ACK.

## Test plan
- After reset, read 0x0 and 0x4: both return 0x00000000. Ack arrives 1 cycle after select; errAck, retry and toutSup stay 0 throughout.
- Pulse user_valid with 0xDEADBEEF, then read 0x4 and 0x0:
  - STATUS reads 0x00010002.
  - DATA reads 0xDEADBEEF.
  - A second STATUS read returns 0x00010000.
- Write 0x00000001 to 0x4 (BE=1111), then pulse user_valid with 0x12345678:
  - DATA still reads the old value, update_count is unchanged, and user_frozen=1.
  - Writing 0 to 0x4 re-enables capture.
- Pulse user_valid 65536 times: update_count wraps to 0x0000 and new_flag=1.
- Pulse user_valid with 0xAAAA5555 in the same cycle as a DATA read hit:
  - The read returns the previous value, and new_flag stays 1.
  - The next DATA read returns 0xAAAA5555.
- Hold OPB_select high for 6 cycles on 0x0, and separately target address C_HIGHADDR+4:
  - Continuous select gives exactly 2 acks, 3 cycles apart.
  - The out-of-range address gives no ack.
  - Asserting OPB_Rst during ACK drops Sl_xferAck immediately.
